// File: rtl/ber_if.sv
// ber_if: sample stream in, BER counts and lock status out, for one ber_counter branch
interface ber_if #(
  parameter int NB_CNT = 64,
  parameter int NB_DLY = 9
);
  logic              i_enb;
  logic              i_valid;
  logic              i_ref_bit;
  logic              i_rx_bit;
  logic              i_clear;
  logic [NB_CNT-1:0] o_samp;
  logic [NB_CNT-1:0] o_error;
  logic              o_locked;
  logic [NB_DLY-1:0] o_delay;
  modport master (
    output i_enb, i_valid, i_ref_bit, i_rx_bit, i_clear,
    input  o_samp, o_error, o_locked, o_delay
  );
  modport slave (
    input  i_enb, i_valid, i_ref_bit, i_rx_bit, i_clear,
    output o_samp, o_error, o_locked, o_delay
  );
endinterface

// File: rtl/ber_counter.sv
// ber_counter: aligns PRBS reference to received bits by delay search, then counts samples and errors
module ber_counter #(
  parameter int NB_CNT      = 64,
  parameter int DELAY_DEPTH = 512,
  parameter int NB_DLY      = 9,
  parameter int WIN_LEN     = 1023,
  parameter int NB_WIN      = 10,
  parameter int LOCK_THR    = 64
) (
  input logic clk,
  input logic i_rst,
  ber_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, SEARCH, LOCKED} state_t;
  localparam logic [NB_DLY-1:0] FILL_LAST = NB_DLY'(DELAY_DEPTH - 2);
  localparam logic [NB_DLY-1:0] DLY_LAST  = NB_DLY'(DELAY_DEPTH - 1);
  localparam logic [NB_WIN-1:0] WIN_LAST  = NB_WIN'(WIN_LEN - 1);
  localparam logic [NB_WIN-1:0] THR       = NB_WIN'(LOCK_THR);
  state_t                 state;
  logic [DELAY_DEPTH-2:0] sr;
  logic [DELAY_DEPTH-1:0] taps;
  logic [NB_DLY-1:0]      fill_cnt, best_d, delay;
  logic [NB_WIN-1:0]      win, werr, best_err, wnew;
  logic [NB_CNT-1:0]      samp, err;
  logic                   locked, smp, mis, win_end;
  // tap 0 is the undelayed reference; tap d is the reference d valid samples ago
  assign taps    = {sr, bus.i_ref_bit};
  assign smp     = bus.i_enb & bus.i_valid;
  assign mis     = bus.i_rx_bit ^ taps[delay];
  assign wnew    = werr + NB_WIN'(mis);
  assign win_end = win == WIN_LAST;
  assign bus.o_samp   = samp;
  assign bus.o_error  = err;
  assign bus.o_locked = locked;
  assign bus.o_delay  = delay;
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      sr       <= '0;
      fill_cnt <= '0;
      best_d   <= '0;
      delay    <= '0;
      win      <= '0;
      werr     <= '0;
      best_err <= '0;
      samp     <= '0;
      err      <= '0;
      locked   <= 1'b0;
    end else begin
      if (smp) sr <= {sr[DELAY_DEPTH-3:0], bus.i_ref_bit};
      if (bus.i_clear) begin
        samp <= '0;
        err  <= '0;
      end else if (state == LOCKED && smp && !(&samp)) begin
        samp <= samp + 1'b1;
        err  <= err + NB_CNT'(mis);
      end
      if (!bus.i_enb) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else case (state)
        IDLE: begin
          state    <= FILL;
          fill_cnt <= '0;
        end
        FILL: if (bus.i_valid) begin
          if (fill_cnt == FILL_LAST) begin
            state    <= SEARCH;
            delay    <= '0;
            win      <= '0;
            werr     <= '0;
            best_err <= '1;
            best_d   <= '0;
          end else fill_cnt <= fill_cnt + 1'b1;
        end
        SEARCH: if (bus.i_valid) begin
          if (!win_end) begin
            win  <= win + 1'b1;
            werr <= wnew;
          end else begin
            win  <= '0;
            werr <= '0;
            if (wnew < best_err) begin
              best_err <= wnew;
              best_d   <= delay;
            end
            // best_err is never zero here, so a clean window always takes the current delay
            if (wnew == '0 || delay == DLY_LAST) begin
              state  <= LOCKED;
              locked <= 1'b1;
              delay  <= (wnew < best_err) ? delay : best_d;
            end else delay <= delay + 1'b1;
          end
        end
        LOCKED: if (bus.i_valid) begin
          if (!win_end) begin
            win  <= win + 1'b1;
            werr <= wnew;
          end else begin
            win  <= '0;
            werr <= '0;
            if (wnew > THR) begin
              state    <= SEARCH;
              locked   <= 1'b0;
              delay    <= '0;
              best_err <= '1;
              best_d   <= '0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: doc/ber_counter.md
Name: ber_counter

Overview:
- Bit-error-rate measurement stage for one branch (I or Q) of the DSP receiver.
- Aligns the local PRBS reference to the received bit stream by searching over reference delays, then accumulates 64-bit sample and error counts.
- Its count outputs drive the register file's i_ber_samp_* / i_ber_error_* inputs.
- One instance per branch.

Parameters:
- NB_CNT, 64: width of the sample and error counters.
- DELAY_DEPTH, 512: number of candidate reference delays, 0..DELAY_DEPTH-1.
- NB_DLY, 9: width of the delay index; must equal clog2(DELAY_DEPTH).
- WIN_LEN, 1023: valid samples per alignment/monitor window.
- NB_WIN, 10: width of the window counters; must hold WIN_LEN.
- LOCK_THR, 64: errors per window above which lock is declared lost.

Ports:
- clk  input  1  system clock.
- i_rst  input  1  asynchronous active-high reset.
- i_enb  input  1  block enable (EnbRx).
- i_valid  input  1  qualifies i_ref_bit and i_rx_bit for this cycle.
- i_ref_bit  input  1  local PRBS reference bit.
- i_rx_bit  input  1  received/decided bit.
- i_clear  input  1  one-cycle pulse; zeroes o_samp and o_error.
- o_samp  output  NB_CNT  compared-sample count.
- o_error  output  NB_CNT  mismatch count.
- o_locked  output  1  high in LOCKED.
- o_delay  output  NB_DLY  selected or current candidate delay.

Behaviour:
- Reset (async, i_rst=1): state=IDLE; shift register, all counters, o_samp, o_error, o_locked, o_delay cleared to 0. All outputs are registered.
- Reference delay line: sr[DELAY_DEPTH-2:0], shifts i_ref_bit into sr[0] on every cycle with i_enb&i_valid.
- Delayed reference for delay d: ref_d = i_ref_bit if d=0, else sr[d-1] (value before this cycle's shift).
- mismatch = i_rx_bit XOR ref_d.
- FSM states: IDLE, FILL, SEARCH, LOCKED.
- Global rule: i_enb=0 in any state -> IDLE next cycle. Counters and o_delay hold; the delay line does not shift; o_locked=0.
- IDLE:
  - i_enb=1 -> FILL, fill counter=0.
- FILL:
  - Counts valid samples; no comparisons.
  - After DELAY_DEPTH-1 valid samples -> SEARCH with d=0, win=0, werr=0, best_err=all-ones, best_d=0.
- SEARCH:
  - Per valid sample: werr += mismatch; win += 1.
  - When win reaches WIN_LEN (including this sample): if werr < best_err (strict; earliest delay wins ties), best_err=werr and best_d=d.
  - If that window's werr==0 -> LOCKED immediately with o_delay=d.
  - Else if d==DELAY_DEPTH-1 -> LOCKED with o_delay=best_d.
  - Else d+=1, win=0, werr=0.
  - o_delay tracks d while searching.
- LOCKED:
  - o_locked=1.
  - Per valid sample: o_samp += 1; o_error += mismatch, both visible the cycle after the sample.
  - Per-window monitor: WIN_LEN-sample windows count errors. At a window's end, if count > LOCK_THR -> SEARCH (full restart, d=0, best reset). o_samp/o_error hold.
  - No direct transition from LOCKED to FILL; the delay line stays populated.
- Saturation: when o_samp is all-ones, neither counter increments; o_error never exceeds o_samp.
- i_clear:
  - In any state: o_samp=0, o_error=0 next cycle. Does not affect FSM, delay line, or window counters.
  - Coincident with a valid sample in LOCKED: clear wins; that sample is not counted.
- Latency: a valid sample affects counts 1 cycle later; lock is declared at the cycle after the window-ending sample.
- i_valid=0 cycles are ignored entirely; no state advances.
- Deassertion of i_rst mid-operation restarts from IDLE.

Test Plan:
- Alignment at delay 37: ref=PRBS9, rx = ref delayed 37 valids, i_valid=1 continuously. Require o_locked=1 after FILL + 38 windows (511 + 38*1023 valid samples), o_delay=37, o_error=0 thereafter. After 10000 more samples, o_samp=10000.
- Error injection: locked at delay 37, flip 1 rx bit every 100 samples for 100000 samples. Require o_samp=100000, o_error=1000, o_locked stays 1 (10 errors per window < 64).
- No zero-error window: rx = delayed ref with 1 flip per 50 samples. Require lock at best delay after all 512 candidates, o_delay=37.
- Loss of lock: locked, then rx replaced by an uncorrelated PRBS. Require SEARCH entered after first window end (o_locked=0), with o_samp/o_error frozen at their values at that instant.
- Clear collision: i_clear coincident with a valid mismatching sample while locked. Require o_samp=0 and o_error=0 next cycle; the following clean sample gives o_samp=1, o_error=0.
- Enable/reset: drop i_enb mid-SEARCH -> o_locked=0, counts hold; reassert -> FILL again. Assert i_rst mid-LOCKED -> all outputs 0 the same cycle (asynchronous).
